// File: rtl/hazard_ctrl_if.sv
// Bus between the hazard controller and the pipeline datapath.
// master: pipeline side, which drives the stage information and consumes the controls.
// slave: the hazard_ctrl side.
//   Inputs to the controller:
//     - s2 source addresses and read enables, plus halt_s2.
//     - s3 source addresses.
//     - s3/s4/s5 destination addresses and active-low write enables.
//     - sel_mem_s3 and branch_taken.
//   Outputs from the controller:
//     - stall_pc, stall_ir, flush_if, bubble_s3.
//     - fwd1_sel and fwd2_sel.
//     - halted.
//     - stall_cnt and flush_cnt.
interface hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_BITS = 5,
  parameter int unsigned CNT_BITS      = 16
);
  logic [REG_ADDR_BITS-1:0] r1_addr_s2;
  logic [REG_ADDR_BITS-1:0] r2_addr_s2;
  logic                     use_r1_s2;
  logic                     use_r2_s2;
  logic                     halt_s2;
  logic [REG_ADDR_BITS-1:0] r1_addr_s3;
  logic [REG_ADDR_BITS-1:0] r2_addr_s3;
  logic [REG_ADDR_BITS-1:0] waddr_s3;
  logic [REG_ADDR_BITS-1:0] waddr_s4;
  logic [REG_ADDR_BITS-1:0] waddr_s5;
  logic                     rw_s3;
  logic                     rw_s4;
  logic                     rw_s5;
  logic                     sel_mem_s3;
  logic                     branch_taken;
  logic                     stall_pc;
  logic                     stall_ir;
  logic                     flush_if;
  logic                     bubble_s3;
  logic [1:0]               fwd1_sel;
  logic [1:0]               fwd2_sel;
  logic                     halted;
  logic [CNT_BITS-1:0]      stall_cnt;
  logic [CNT_BITS-1:0]      flush_cnt;

  modport master (
    output r1_addr_s2, r2_addr_s2, use_r1_s2, use_r2_s2, halt_s2,
           r1_addr_s3, r2_addr_s3, waddr_s3, waddr_s4, waddr_s5,
           rw_s3, rw_s4, rw_s5, sel_mem_s3, branch_taken,
    input  stall_pc, stall_ir, flush_if, bubble_s3, fwd1_sel, fwd2_sel,
           halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  r1_addr_s2, r2_addr_s2, use_r1_s2, use_r2_s2, halt_s2,
           r1_addr_s3, r2_addr_s3, waddr_s3, waddr_s4, waddr_s5,
           rw_s3, rw_s4, rw_s5, sel_mem_s3, branch_taken,
    output stall_pc, stall_ir, flush_if, bubble_s3, fwd1_sel, fwd2_sel,
           halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline.
//   - Detects RAW hazards on decode operands and raises stall_pc, stall_ir and bubble_s3.
//   - Squashes the wrong path on a taken branch using flush_if and bubble_s3.
//   - Produces the EX forwarding selects.
//   - On halt_s2 it drains the pipeline for DRAIN_CYCLES cycles, then freezes with halted set.
//   - Keeps saturating stall and flush counters.
// Ports:
//   - clk and rst: synchronous, active-high reset.
//   - bus: the hazard_ctrl_if slave modport.
// Build option: the HAZARD_FWD_EN macro selects the forwarding build.
//   - In that build, only a load in s3 interlocks and the forwarding selects are live.
//   - Otherwise, every valid s3/s4/s5 writer interlocks and the forwarding selects are 00.
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_BITS = 5,
  parameter int unsigned DRAIN_CYCLES  = 3,
  parameter int unsigned CNT_BITS      = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);
  localparam int unsigned DRAIN_BITS = 4;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [DRAIN_BITS-1:0] drain_cnt, drain_nxt;
  logic [CNT_BITS-1:0]   stall_cnt_q, flush_cnt_q;
  logic                  stall_evt, flush_evt;
  logic                  hazard;
  logic                  valid_s3, valid_s4, valid_s5;
  logic                  rel_s3, rel_s4, rel_s5;
  logic                  stall_pc_c, stall_ir_c, flush_if_c, bubble_c, halted_c;
  logic [1:0]            fwd1_c, fwd2_c;

  // A stage is a valid writer when its write enable is low and its target is not r0.
  assign valid_s3 = !bus.rw_s3 && (bus.waddr_s3 != '0);
  assign valid_s4 = !bus.rw_s4 && (bus.waddr_s4 != '0);
  assign valid_s5 = !bus.rw_s5 && (bus.waddr_s5 != '0);

  function automatic logic [1:0] fwd_pick(input logic [REG_ADDR_BITS-1:0] src,
                                          input logic v4, input logic [REG_ADDR_BITS-1:0] w4,
                                          input logic v5, input logic [REG_ADDR_BITS-1:0] w5);
    if (v4 && (src == w4))      fwd_pick = 2'b01;
    else if (v5 && (src == w5)) fwd_pick = 2'b10;
    else                        fwd_pick = 2'b00;
  endfunction

`ifdef HAZARD_FWD_EN
  // With forwarding, only a load in EX cannot be bypassed in time.
  assign rel_s3 = valid_s3 && bus.sel_mem_s3;
  assign rel_s4 = 1'b0;
  assign rel_s5 = 1'b0;
  assign fwd1_c = fwd_pick(bus.r1_addr_s3, valid_s4, bus.waddr_s4, valid_s5, bus.waddr_s5);
  assign fwd2_c = fwd_pick(bus.r2_addr_s3, valid_s4, bus.waddr_s4, valid_s5, bus.waddr_s5);
`else
  logic unused_fwd_inputs;
  assign rel_s3 = valid_s3;
  assign rel_s4 = valid_s4;
  assign rel_s5 = valid_s5;
  assign fwd1_c = 2'b00;
  assign fwd2_c = 2'b00;
  assign unused_fwd_inputs = ^{bus.sel_mem_s3, bus.r1_addr_s3, bus.r2_addr_s3,
                               fwd_pick('0, 1'b0, '0, 1'b0, '0)};
`endif

  // The valid-writer terms already exclude r0, so a source of r0 can never match.
  assign hazard =
    (bus.use_r1_s2 && ((rel_s3 && bus.r1_addr_s2 == bus.waddr_s3) ||
                       (rel_s4 && bus.r1_addr_s2 == bus.waddr_s4) ||
                       (rel_s5 && bus.r1_addr_s2 == bus.waddr_s5))) ||
    (bus.use_r2_s2 && ((rel_s3 && bus.r2_addr_s2 == bus.waddr_s3) ||
                       (rel_s4 && bus.r2_addr_s2 == bus.waddr_s4) ||
                       (rel_s5 && bus.r2_addr_s2 == bus.waddr_s5)));

  // State, drain counter and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      drain_cnt   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_BITS'(1);
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_BITS'(1);
    end
  end

  // Next state and control outputs; a branch outranks a hazard, which outranks a halt.
  always_comb begin
    state_nxt  = state;
    drain_nxt  = drain_cnt;
    stall_pc_c = 1'b0;
    stall_ir_c = 1'b0;
    flush_if_c = 1'b0;
    bubble_c   = 1'b0;
    halted_c   = 1'b0;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;
    case (state)
      RUN: begin
        if (bus.branch_taken) begin
          flush_if_c = 1'b1;
          bubble_c   = 1'b1;
          flush_evt  = 1'b1;
        end else if (hazard) begin
          stall_pc_c = 1'b1;
          stall_ir_c = 1'b1;
          bubble_c   = 1'b1;
          stall_evt  = 1'b1;
        end else if (bus.halt_s2) begin
          // The HALT itself still moves on to s3; only fetch is frozen.
          stall_pc_c = 1'b1;
          flush_if_c = 1'b1;
          state_nxt  = DRAIN;
          drain_nxt  = '0;
        end
      end
      DRAIN: begin
        stall_pc_c = 1'b1;
        flush_if_c = 1'b1;
        drain_nxt  = drain_cnt + DRAIN_BITS'(1);
        if (drain_cnt == DRAIN_BITS'(DRAIN_CYCLES - 1)) state_nxt = HALTED;
      end
      HALTED: begin
        stall_pc_c = 1'b1;
        flush_if_c = 1'b1;
        halted_c   = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Every output is forced low while reset is held.
  assign bus.stall_pc  = !rst && stall_pc_c;
  assign bus.stall_ir  = !rst && stall_ir_c;
  assign bus.flush_if  = !rst && flush_if_c;
  assign bus.bubble_s3 = !rst && bubble_c;
  assign bus.halted    = !rst && halted_c;
  assign bus.fwd1_sel  = rst ? 2'b00 : fwd1_c;
  assign bus.fwd2_sel  = rst ? 2'b00 : fwd2_c;
  assign bus.stall_cnt = rst ? '0 : stall_cnt_q;
  assign bus.flush_cnt = rst ? '0 : flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_hazard_ctrl;
  localparam int unsigned RAB  = 5;
  localparam int unsigned DC   = 3;
  localparam int unsigned CB   = 4;
  localparam int          CMAX = (1 << CB) - 1;
  localparam int unsigned OW   = 9 + 2 * CB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_BITS(RAB), .CNT_BITS(CB)) bus ();

  hazard_ctrl #(.REG_ADDR_BITS(RAB), .DRAIN_CYCLES(DC), .CNT_BITS(CB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycle number, cycle in which HALT was accepted (-1 = none), event counts.
  int cyc     = 0;
  int halt_at = -1;
  int m_stall = 0;
  int m_flush = 0;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  function automatic logic [1:0] exp_fwd(input logic [RAB-1:0] src);
    if (FWD && src != 0 && !bus.rw_s4 && src == bus.waddr_s4) return 2'b01;
    if (FWD && src != 0 && !bus.rw_s5 && src == bus.waddr_s5) return 2'b10;
    return 2'b00;
  endfunction

  // True when some relevant in-flight writer targets a register decode wants to read.
  function automatic logic exp_hazard();
    logic [RAB-1:0] w[3];
    logic           wr[3];
    w  = '{bus.waddr_s3, bus.waddr_s4, bus.waddr_s5};
    wr = '{!bus.rw_s3 && (!FWD || bus.sel_mem_s3), !bus.rw_s4 && !FWD, !bus.rw_s5 && !FWD};
    for (int i = 0; i < 3; i++) begin
      if (wr[i] && w[i] != 0 &&
          ((bus.use_r1_s2 && bus.r1_addr_s2 == w[i]) || (bus.use_r2_s2 && bus.r2_addr_s2 == w[i])))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [OW-1:0] model_out();
    logic sp, si, fi, bb, hl;
    sp = 0; si = 0; fi = 0; bb = 0; hl = 0;
    if (rst) return '0;
    if (halt_at < 0) begin
      if (bus.branch_taken) begin fi = 1; bb = 1; end
      else if (exp_hazard()) begin sp = 1; si = 1; bb = 1; end
      else if (bus.halt_s2) begin sp = 1; fi = 1; end
    end else begin
      sp = 1; fi = 1;
      hl = (cyc > halt_at + int'(DC));
    end
    return {sp, si, fi, bb, exp_fwd(bus.r1_addr_s3), exp_fwd(bus.r2_addr_s3), hl,
            CB'(m_stall), CB'(m_flush)};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {bus.stall_pc, bus.stall_ir, bus.flush_if, bus.bubble_s3, bus.fwd1_sel, bus.fwd2_sel,
            bus.halted, bus.stall_cnt, bus.flush_cnt};
  endfunction

  // Advance the model on every edge using the inputs held stable across it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      halt_at <= -1;
      m_stall <= 0;
      m_flush <= 0;
    end else if (halt_at < 0) begin
      if (bus.branch_taken) m_flush <= (m_flush == CMAX) ? m_flush : m_flush + 1;
      else if (exp_hazard()) m_stall <= (m_stall == CMAX) ? m_stall : m_stall + 1;
      else if (bus.halt_s2) halt_at <= cyc;
    end
  end

  task automatic idle();
    bus.r1_addr_s2 = '0; bus.r2_addr_s2 = '0; bus.use_r1_s2 = 0; bus.use_r2_s2 = 0;
    bus.halt_s2 = 0; bus.r1_addr_s3 = '0; bus.r2_addr_s3 = '0;
    bus.waddr_s3 = '0; bus.waddr_s4 = '0; bus.waddr_s5 = '0;
    bus.rw_s3 = 1; bus.rw_s4 = 1; bus.rw_s5 = 1; bus.sel_mem_s3 = 0; bus.branch_taken = 0;
  endtask

  task automatic drive_random();
    bus.r1_addr_s2 = RAB'($urandom_range(0, 7)); bus.r2_addr_s2 = RAB'($urandom_range(0, 7));
    bus.use_r1_s2 = 1'($urandom); bus.use_r2_s2 = 1'($urandom);
    bus.r1_addr_s3 = RAB'($urandom_range(0, 7)); bus.r2_addr_s3 = RAB'($urandom_range(0, 7));
    bus.waddr_s3 = RAB'($urandom_range(0, 7)); bus.waddr_s4 = RAB'($urandom_range(0, 7));
    bus.waddr_s5 = RAB'($urandom_range(0, 7));
    bus.rw_s3 = ($urandom % 3 == 0); bus.rw_s4 = ($urandom % 3 == 0); bus.rw_s5 = ($urandom % 3 == 0);
    bus.sel_mem_s3 = ($urandom % 3 == 0);
    bus.branch_taken = ($urandom % 6 == 0);
    bus.halt_s2 = ($urandom % 25 == 0);
  endtask

  task automatic load_use();
    bus.sel_mem_s3 = 1; bus.rw_s3 = 0; bus.waddr_s3 = RAB'(3);
    bus.r1_addr_s2 = RAB'(3); bus.use_r1_s2 = 1;
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1; idle();
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rst = 1; drive_random(); #1;
      n_checks++;
      if (dut_out() !== '0) begin
        n_fail++; $display("FAIL reset_outputs: got %0h expected 0", dut_out());
      end
    end
    @(negedge clk); rst = 0; idle(); #1;
    n_checks++;
    if ({bus.halted, bus.stall_pc, bus.stall_cnt, bus.flush_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_release: got halted=%0b stall_pc=%0b stall_cnt=%0d flush_cnt=%0d expected all 0",
                         bus.halted, bus.stall_pc, bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    load_use(); #1;
    n_checks++;
    if ({bus.stall_pc, bus.stall_ir, bus.bubble_s3, bus.flush_if} !== 4'b1110) begin
      n_fail++; $display("FAIL load_use_ctrl: got %b expected 1110",
                         {bus.stall_pc, bus.stall_ir, bus.bubble_s3, bus.flush_if});
    end
    @(negedge clk); idle(); #1;
    n_checks++;
    if (bus.stall_cnt !== CB'(1) || bus.stall_pc !== 1'b0) begin
      n_fail++; $display("FAIL load_use_count: got stall_cnt=%0d stall_pc=%0b expected 1/0",
                         bus.stall_cnt, bus.stall_pc);
    end
  endtask

  task automatic test_forward();
    logic [1:0] e_s4, e_s5;
    e_s4 = FWD ? 2'b01 : 2'b00;
    e_s5 = FWD ? 2'b10 : 2'b00;
    @(negedge clk); idle();
    bus.waddr_s4 = RAB'(5); bus.rw_s4 = 0; bus.waddr_s5 = RAB'(5); bus.rw_s5 = 0;
    bus.r1_addr_s3 = RAB'(5); #1;
    n_checks++;
    if (bus.fwd1_sel !== e_s4) begin
      n_fail++; $display("FAIL fwd_s4_priority: got %b expected %b", bus.fwd1_sel, e_s4);
    end
    @(negedge clk); bus.rw_s4 = 1; bus.r2_addr_s3 = RAB'(5); #1;
    n_checks++;
    if ({bus.fwd1_sel, bus.fwd2_sel} !== {e_s5, e_s5}) begin
      n_fail++; $display("FAIL fwd_s5: got %b/%b expected %b", bus.fwd1_sel, bus.fwd2_sel, e_s5);
    end
    @(negedge clk); bus.r1_addr_s3 = '0; bus.waddr_s5 = '0; bus.r2_addr_s3 = '0; #1;
    n_checks++;
    if ({bus.fwd1_sel, bus.fwd2_sel} !== 4'b0000) begin
      n_fail++; $display("FAIL fwd_r0: got %b/%b expected 00/00", bus.fwd1_sel, bus.fwd2_sel);
    end
  endtask

  task automatic test_interlock();
    int stalls = 0;
    int exp_n;
    exp_n = FWD ? 0 : 3;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      idle();
      bus.r2_addr_s2 = RAB'(7); bus.use_r2_s2 = 1;
      if (k == 0) begin bus.waddr_s3 = RAB'(7); bus.rw_s3 = 0; end
      if (k == 1) begin bus.waddr_s4 = RAB'(7); bus.rw_s4 = 0; end
      if (k == 2) begin bus.waddr_s5 = RAB'(7); bus.rw_s5 = 0; end
      #1;
      if (bus.stall_pc) stalls++;
    end
    @(negedge clk); idle(); #1;
    n_checks++;
    if (stalls != exp_n || bus.stall_cnt !== CB'(exp_n)) begin
      n_fail++; $display("FAIL interlock_stalls: got %0d cycles cnt=%0d expected %0d", stalls, bus.stall_cnt, exp_n);
    end
  endtask

  task automatic test_branch_hazard();
    apply_reset();
    load_use(); bus.branch_taken = 1; #1;
    n_checks++;
    if ({bus.flush_if, bus.bubble_s3, bus.stall_pc, bus.stall_ir} !== 4'b1100) begin
      n_fail++; $display("FAIL branch_hazard_ctrl: got %b expected 1100",
                         {bus.flush_if, bus.bubble_s3, bus.stall_pc, bus.stall_ir});
    end
    @(negedge clk); idle(); #1;
    n_checks++;
    if (bus.flush_cnt !== CB'(1) || bus.stall_cnt !== CB'(0)) begin
      n_fail++; $display("FAIL branch_counts: got flush=%0d stall=%0d expected 1/0", bus.flush_cnt, bus.stall_cnt);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    bus.halt_s2 = 1; #1;
    n_checks++;
    if ({bus.stall_pc, bus.flush_if, bus.halted, bus.stall_ir} !== 4'b1100) begin
      n_fail++; $display("FAIL halt_accept: got %b expected 1100", {bus.stall_pc, bus.flush_if, bus.halted, bus.stall_ir});
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); drive_random(); #1;
      n_checks++;
      if ({bus.stall_pc, bus.flush_if, bus.bubble_s3, bus.halted} !== {3'b110, (k >= int'(DC) + 1)}) begin
        n_fail++; $display("FAIL halt_drain_n%0d: got %b expected %b", k,
                           {bus.stall_pc, bus.flush_if, bus.bubble_s3, bus.halted}, {3'b110, (k >= int'(DC) + 1)});
      end
    end
  endtask

  task automatic test_halt_reset();
    apply_reset();
    bus.halt_s2 = 1;
    @(negedge clk); idle();
    @(negedge clk); rst = 1; #1;
    n_checks++;
    if (dut_out() !== '0) begin
      n_fail++; $display("FAIL halt_rst_outputs: got %0h expected 0", dut_out());
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); rst = 0; idle(); #1;
      n_checks++;
      if (bus.halted !== 1'b0 || bus.stall_pc !== 1'b0) begin
        n_fail++; $display("FAIL halt_rst_run_%0d: got halted=%0b stall_pc=%0b expected 0/0", k, bus.halted, bus.stall_pc);
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      idle(); load_use();
    end
    @(negedge clk); idle(); #1;
    n_checks++;
    if (bus.stall_cnt !== CB'(CMAX)) begin
      n_fail++; $display("FAIL stall_saturate: got %0d expected %0d", bus.stall_cnt, CMAX);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rst = ($urandom % 80 == 0);
      drive_random(); #1;
      n_checks++;
      if (dut_out() !== model_out()) begin
        n_fail++; $display("FAIL random_cycle_%0d: got %0h expected %0h", k, dut_out(), model_out());
      end
    end
    @(negedge clk); rst = 0;
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_forward();
    test_interlock();
    test_branch_hazard();
    test_halt();
    test_halt_reset();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
